// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals shared by the
// memory port arbiter and whatever drives/observes it.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic [31:0]           f_rdata;
    logic                  f_done;

    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic [3:0]            d_wmask;
    logic [31:0]           d_rdata;
    logic                  d_done;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wmask;
    logic                  mem_rstrb;
    logic [31:0]           mem_rdata;

    logic [1:0]            grant;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
        output f_rdata, f_done, d_rdata, d_done,
               mem_addr, mem_wdata, mem_wmask, mem_rstrb, grant
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
        input  f_rdata, f_done, d_rdata, d_done,
               mem_addr, mem_wdata, mem_wmask, mem_rstrb, grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one word-addressed
// memory with 1-cycle read latency, steering read data back to the winner.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter bit FAIR       = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_data_q, last_data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [31:0]           f_rdata_q, f_rdata_d;
    logic [31:0]           d_rdata_q, d_rdata_d;
    logic                  pick_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            last_data_q <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_data_q <= last_data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_data_d = last_data_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        // On conflict the data port wins unless fair mode and data went last.
        pick_data   = bus.d_req && (!bus.f_req || !FAIR || !last_data_q);

        case (state_q)
            S_IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    grant_d     = pick_data ? 2'b10 : 2'b01;
                    last_data_d = pick_data;
                    addr_d      = pick_data ? bus.d_addr  : bus.f_addr;
                    wdata_d     = pick_data ? bus.d_wdata : 32'h0;
                    wmask_d     = pick_data ? bus.d_wmask : 4'b0000;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wmask_q == 4'b0000) begin
                    if (grant_q[1]) d_rdata_d = bus.mem_rdata;
                    else            f_rdata_d = bus.mem_rdata;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode from state so an async reset removes them without a clock.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = (state_q == S_ISSUE) ? wmask_q : 4'b0000;
    assign bus.mem_rstrb = (state_q == S_ISSUE) && (wmask_q == 4'b0000);
    assign bus.grant     = grant_q;
    assign bus.f_done    = (state_q == S_DONE) && grant_q[0];
    assign bus.d_done    = (state_q == S_DONE) && grant_q[1];
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a fair instance and a fixed-priority
// instance, each with its own behavioural 256-word memory.
module tb_mem_port_arbiter;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) b0 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) b1 ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .FAIR(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    mem_port_arbiter #(.ADDR_WIDTH(AW), .FAIR(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    logic [31:0]   mem0 [0:255];
    logic [31:0]   mem1 [0:255];
    logic          poke0_en = 1'b0;
    logic          poke1_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [31:0]   poke_data = '0;

    always @(posedge clk) begin
        if (poke0_en) mem0[poke_addr] <= poke_data;
        if (b0.mem_rstrb) b0.mem_rdata <= mem0[b0.mem_addr];
        for (int b = 0; b < 4; b++)
            if (b0.mem_wmask[b]) mem0[b0.mem_addr][8*b +: 8] <= b0.mem_wdata[8*b +: 8];
    end

    always @(posedge clk) begin
        if (poke1_en) mem1[poke_addr] <= poke_data;
        if (b1.mem_rstrb) b1.mem_rdata <= mem1[b1.mem_addr];
        for (int b = 0; b < 4; b++)
            if (b1.mem_wmask[b]) mem1[b1.mem_addr][8*b +: 8] <= b1.mem_wdata[8*b +: 8];
    end

    int fd0 = 0, dd0 = 0, fd1 = 0, dd1 = 0, both0 = 0;
    always @(posedge clk) begin
        if (b0.f_done) fd0 <= fd0 + 1;
        if (b0.d_done) dd0 <= dd0 + 1;
        if (b1.f_done) fd1 <= fd1 + 1;
        if (b1.d_done) dd1 <= dd1 + 1;
        if (b0.f_done && b0.d_done) both0 <= both0 + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke0(input logic [AW-1:0] a, input logic [31:0] d);
        poke_addr = a; poke_data = d; poke0_en = 1'b1;
        step();
        poke0_en = 1'b0;
    endtask

    task automatic poke1(input logic [AW-1:0] a, input logic [31:0] d);
        poke_addr = a; poke_data = d; poke1_en = 1'b1;
        step();
        poke1_en = 1'b0;
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0: done_of = b0.f_done;
            1: done_of = b0.d_done;
            2: done_of = b1.f_done;
            default: done_of = b1.d_done;
        endcase
    endfunction

    // Returns the number of edges until the selected done is seen, 99 on timeout.
    task automatic wait_done(input int sel, output int n);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done_of(sel) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (b0.grant !== 2'b00) begin errors++; $display("FAIL reset_grant0: got %b want 00", b0.grant); end
        checks++; if (b1.grant !== 2'b00) begin errors++; $display("FAIL reset_grant1: got %b want 00", b1.grant); end
        checks++; if ({b0.f_done, b0.d_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {b0.f_done, b0.d_done}); end
        checks++; if (b0.f_rdata !== 32'h0) begin errors++; $display("FAIL reset_f_rdata: got %h want 0", b0.f_rdata); end
        checks++; if (b0.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", b0.d_rdata); end
        checks++; if ({b0.mem_rstrb, b0.mem_wmask} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {b0.mem_rstrb, b0.mem_wmask}); end
        checks++; if ({b0.mem_addr, b0.mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", b0.mem_addr, b0.mem_wdata); end
    endtask

    task automatic test_single_fetch();
        b0.f_addr = 8'd3;
        b0.f_req  = 1'b1;
        step();
        checks++; if (b0.grant !== 2'b01) begin errors++; $display("FAIL fetch_issue_grant: got %b want 01", b0.grant); end
        checks++; if (b0.mem_rstrb !== 1'b1) begin errors++; $display("FAIL fetch_issue_rstrb: got %b want 1", b0.mem_rstrb); end
        checks++; if (b0.mem_addr !== 8'd3) begin errors++; $display("FAIL fetch_issue_addr: got %0d want 3", b0.mem_addr); end
        step();
        checks++; if (b0.mem_rstrb !== 1'b0) begin errors++; $display("FAIL fetch_wait_rstrb: got %b want 0", b0.mem_rstrb); end
        checks++; if (b0.grant !== 2'b01) begin errors++; $display("FAIL fetch_wait_grant: got %b want 01", b0.grant); end
        checks++; if (b0.f_done !== 1'b0) begin errors++; $display("FAIL fetch_wait_done: got %b want 0", b0.f_done); end
        step();
        checks++; if (b0.f_done !== 1'b1) begin errors++; $display("FAIL fetch_done: got %b want 1", b0.f_done); end
        checks++; if (b0.f_rdata !== 32'h00100093) begin errors++; $display("FAIL fetch_rdata: got %h want 00100093", b0.f_rdata); end
        b0.f_req = 1'b0;
        step();
        checks++; if (b0.f_done !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse: got %b want 0", b0.f_done); end
        checks++; if (b0.grant !== 2'b00) begin errors++; $display("FAIL fetch_idle_grant: got %b want 00", b0.grant); end
    endtask

    task automatic test_data_write_read();
        int n;
        b0.d_addr  = 8'd5;
        b0.d_wdata = 32'hAABBCCDD;
        b0.d_wmask = 4'b0011;
        b0.d_req   = 1'b1;
        step();
        checks++; if (b0.grant !== 2'b10) begin errors++; $display("FAIL write_grant: got %b want 10", b0.grant); end
        checks++; if (b0.mem_wmask !== 4'b0011 || b0.mem_rstrb !== 1'b0) begin errors++; $display("FAIL write_issue_strobes: got %b/%b want 0011/0", b0.mem_wmask, b0.mem_rstrb); end
        checks++; if (b0.mem_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL write_wdata: got %h want aabbccdd", b0.mem_wdata); end
        wait_done(1, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL write_latency: got %0d want 2 more edges", n); end
        checks++; if (b0.d_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata_kept: got %h want 0", b0.d_rdata); end
        b0.d_req = 1'b0;
        step();
        checks++; if (mem0[5] !== 32'h1122CCDD) begin errors++; $display("FAIL write_mem: got %h want 1122ccdd", mem0[5]); end
        b0.d_wmask = 4'b0000;
        b0.d_req   = 1'b1;
        wait_done(1, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", n); end
        checks++; if (b0.d_rdata !== 32'h1122CCDD) begin errors++; $display("FAIL read_rdata: got %h want 1122ccdd", b0.d_rdata); end
        b0.d_req = 1'b0;
        step();
    endtask

    task automatic test_fair_conflict();
        logic [1:0] exp_g [4];
        int n, both_before;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        reset = 1'b0;
        step();
        reset = 1'b1;
        both_before = both0;
        b0.f_addr = 8'd3; b0.d_addr = 8'd5; b0.d_wmask = 4'b0000;
        b0.f_req = 1'b1; b0.d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (b0.grant !== exp_g[k]) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", k, b0.grant, exp_g[k]); end
            wait_done(exp_g[k][1] ? 1 : 0, n);
            checks++; if (n !== 2) begin errors++; $display("FAIL fair_latency%0d: got %0d want 2", k, n); end
            if (exp_g[k][1]) begin
                checks++; if (b0.d_rdata !== 32'h1122CCDD) begin errors++; $display("FAIL fair_d_rdata%0d: got %h want 1122ccdd", k, b0.d_rdata); end
                b0.d_req = 1'b0; step(); b0.d_req = 1'b1;
            end else begin
                checks++; if (b0.f_rdata !== 32'h00100093) begin errors++; $display("FAIL fair_f_rdata%0d: got %h want 00100093", k, b0.f_rdata); end
                b0.f_req = 1'b0; step(); b0.f_req = 1'b1;
            end
        end
        b0.f_req = 1'b0; b0.d_req = 1'b0;
        step();
        checks++; if (both0 !== both_before) begin errors++; $display("FAIL fair_dual_done: got %0d want %0d", both0, both_before); end
        checks++; if (b0.grant !== 2'b00) begin errors++; $display("FAIL fair_idle_grant: got %b want 00", b0.grant); end
    endtask

    task automatic test_fixed_priority();
        int n, f_before, d_before;
        poke1(8'd7, 32'hCAFEF00D);
        poke1(8'd2, 32'h12345678);
        f_before = fd1; d_before = dd1;
        b1.f_addr = 8'd2; b1.d_addr = 8'd7; b1.d_wmask = 4'b0000;
        b1.f_req = 1'b1; b1.d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(3, n);
            checks++; if (n !== ((k == 0) ? 3 : 4)) begin errors++; $display("FAIL fixed_d_latency%0d: got %0d want %0d", k, n, (k == 0) ? 3 : 4); end
            checks++; if (b1.f_done !== 1'b0) begin errors++; $display("FAIL fixed_no_fetch%0d: got %b want 0", k, b1.f_done); end
        end
        b1.d_req = 1'b0;
        wait_done(2, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL fixed_fetch_latency: got %0d want 4", n); end
        checks++; if (b1.f_rdata !== 32'h12345678) begin errors++; $display("FAIL fixed_f_rdata: got %h want 12345678", b1.f_rdata); end
        checks++; if (b1.d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL fixed_d_rdata: got %h want cafef00d", b1.d_rdata); end
        checks++; if (dd1 - d_before !== 4) begin errors++; $display("FAIL fixed_d_count: got %0d want 4", dd1 - d_before); end
        checks++; if (fd1 - f_before !== 0) begin errors++; $display("FAIL fixed_f_count: got %0d want 0", fd1 - f_before); end
        b1.f_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_issue();
        int n, d_before;
        poke0(8'd9, 32'h55555555);
        d_before = dd0;
        b0.d_addr = 8'd9; b0.d_wdata = 32'hDEADBEEF; b0.d_wmask = 4'b1111;
        b0.d_req = 1'b1;
        step();
        checks++; if (b0.mem_wmask !== 4'b1111) begin errors++; $display("FAIL rst_issue_wmask: got %b want 1111", b0.mem_wmask); end
        #2 reset = 1'b0;
        #1;
        checks++; if (b0.mem_wmask !== 4'b0000) begin errors++; $display("FAIL rst_async_wmask: got %b want 0000", b0.mem_wmask); end
        checks++; if (b0.grant !== 2'b00) begin errors++; $display("FAIL rst_async_grant: got %b want 00", b0.grant); end
        b0.d_req = 1'b0; b0.d_wmask = 4'b0000;
        step();
        reset = 1'b1;
        step(); step(); step();
        checks++; if (dd0 !== d_before) begin errors++; $display("FAIL rst_no_done: got %0d want %0d", dd0, d_before); end
        checks++; if (mem0[9] !== 32'h55555555) begin errors++; $display("FAIL rst_mem_kept: got %h want 55555555", mem0[9]); end
        b0.f_addr = 8'd9; b0.f_req = 1'b1;
        wait_done(0, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL rst_after_latency: got %0d want 3", n); end
        checks++; if (b0.f_rdata !== 32'h55555555) begin errors++; $display("FAIL rst_after_rdata: got %h want 55555555", b0.f_rdata); end
        b0.f_req = 1'b0;
        step();
    endtask

    task automatic test_drop_early();
        int f_before, strobes;
        poke0(8'd4, 32'h0BADF00D);
        f_before = fd0;
        b0.f_addr = 8'd4; b0.f_req = 1'b1;
        step();
        b0.f_req = 1'b0; b0.f_addr = 8'd3;
        b0.d_addr = 8'd1; b0.d_wdata = 32'hFFFFFFFF;
        strobes = (b0.mem_rstrb === 1'b1) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (b0.mem_rstrb === 1'b1) strobes++;
        end
        checks++; if (strobes !== 1) begin errors++; $display("FAIL drop_strobes: got %0d want 1", strobes); end
        checks++; if (fd0 - f_before !== 1) begin errors++; $display("FAIL drop_done_count: got %0d want 1", fd0 - f_before); end
        checks++; if (b0.f_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL drop_rdata: got %h want 0badf00d", b0.f_rdata); end
        checks++; if (b0.grant !== 2'b00) begin errors++; $display("FAIL drop_idle_grant: got %b want 00", b0.grant); end
    endtask

    initial begin
        b0.f_req = 1'b0; b0.f_addr = '0; b0.d_req = 1'b0; b0.d_addr = '0; b0.d_wdata = '0; b0.d_wmask = '0;
        b1.f_req = 1'b0; b1.f_addr = '0; b1.d_req = 1'b0; b1.d_addr = '0; b1.d_wdata = '0; b1.d_wmask = '0;
        poke0(8'd3, 32'h00100093);
        poke0(8'd5, 32'h11223344);
        test_reset();
        reset = 1'b1;
        step();
        test_single_fetch();
        test_data_write_read();
        test_fair_conflict();
        test_fixed_priority();
        test_reset_mid_issue();
        test_drop_early();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end within 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
